// File: rtl/reg_op_sequencer.sv
//==============================================================================
// Module   : reg_op_sequencer
// Brief    : Register-file initiator: read, execute, write back one op per 4 cycles.
//            Optional Z/C flags and CMP behaviour enabled by `REGSEQ_FLAGS_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module reg_op_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_op,
   input  logic [1:0] in_dst,
   input  logic [1:0] in_srca,
   input  logic [1:0] in_srcb,
   input  logic [7:0] in_imm,
   input  logic       stall,
   output logic [1:0] aa,
   output logic [1:0] ab,
   input  logic [7:0] ra,
   input  logic [7:0] rb,
   output logic       wr,
   output logic [1:0] ad,
   output logic [7:0] rd,
   output logic       addr_lock,
   output logic       flag_z,
   output logic       flag_c,
   output logic       done
);

   localparam logic [2:0] c_OP_MOV = 3'd0;
   localparam logic [2:0] c_OP_ADD = 3'd1;
   localparam logic [2:0] c_OP_SUB = 3'd2;
   localparam logic [2:0] c_OP_AND = 3'd3;
   localparam logic [2:0] c_OP_OR  = 3'd4;
   localparam logic [2:0] c_OP_XOR = 3'd5;
   localparam logic [2:0] c_OP_LDI = 3'd6;
   localparam logic [2:0] c_OP_CMP = 3'd7;

`ifdef REGSEQ_FLAGS_EN
   localparam int c_RES_W = 9;
`else
   localparam int c_RES_W = 8;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [2:0]           r_op;
   logic [1:0]           r_dst;
   logic [7:0]           r_imm;
   logic [7:0]           r_opa;
   logic [7:0]           r_opb;
   logic [1:0]           r_aa;
   logic [1:0]           r_ab;
   logic [1:0]           r_ad;
   logic [7:0]           r_rd;
   logic [c_RES_W-1:0]   w_res;
   logic                 w_ready;
   logic                 w_wr;
   logic                 w_done;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_wr    = 1'b0;
      w_done  = 1'b0;
      if (rst_n && !stall) begin
         case (r_state)
            S_IDLE: begin
               w_ready = 1'b1;
               if (in_valid) w_next = S_READ;
            end
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
               w_wr   = (r_op != c_OP_CMP);
               w_done = 1'b1;
               w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Result width follows the flag build: bit 8 only exists when carry is kept.
   always_comb begin
      w_res = '0;
      case (r_op)
         c_OP_MOV: w_res = c_RES_W'(r_opa);
         c_OP_ADD: w_res = c_RES_W'({1'b0, r_opa}) + c_RES_W'({1'b0, r_opb});
         c_OP_SUB,
         c_OP_CMP: w_res = c_RES_W'({1'b0, r_opa}) - c_RES_W'({1'b0, r_opb});
         c_OP_AND: w_res = c_RES_W'(r_opa & r_opb);
         c_OP_OR:  w_res = c_RES_W'(r_opa | r_opb);
         c_OP_XOR: w_res = c_RES_W'(r_opa ^ r_opb);
         c_OP_LDI: w_res = c_RES_W'(r_imm);
         default:  w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op  <= c_OP_MOV;
         r_dst <= 2'd0;
         r_imm <= 8'd0;
         r_opa <= 8'd0;
         r_opb <= 8'd0;
         r_aa  <= 2'd0;
         r_ab  <= 2'd0;
         r_ad  <= 2'd0;
         r_rd  <= 8'd0;
      end else if (!stall) begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op  <= in_op;
                  r_dst <= in_dst;
                  r_imm <= in_imm;
                  r_aa  <= in_srca;
                  r_ab  <= in_srcb;
               end
            end
            S_READ: begin
               r_opa <= ra;
               r_opb <= rb;
            end
            S_EXEC: begin
               r_ad <= r_dst;
               r_rd <= w_res[7:0];
            end
            default: ;
         endcase
      end
   end

`ifdef REGSEQ_FLAGS_EN
   logic r_fz;
   logic r_fc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fz <= 1'b0;
         r_fc <= 1'b0;
      end else if (!stall && r_state == S_EXEC && r_op != c_OP_MOV && r_op != c_OP_LDI) begin
         r_fz <= (w_res[7:0] == 8'd0);
         r_fc <= w_res[8];
      end
   end

   assign flag_z = r_fz;
   assign flag_c = r_fc;
`else
   assign flag_z = 1'b0;
   assign flag_c = 1'b0;
`endif

   assign in_ready  = w_ready;
   assign wr        = w_wr;
   assign done      = w_done;
   assign addr_lock = stall;
   assign aa        = r_aa;
   assign ab        = r_ab;
   assign ad        = r_ad;
   assign rd        = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
//==============================================================================
// Module   : tb_reg_op_sequencer
// Brief    : Directed vector bench with a behavioural 4-entry register file.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_reg_op_sequencer;

   localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
   localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, LDI = 3'd6, CMP = 3'd7;
   localparam logic [1:0] AX = 2'd0, BX = 2'd1, CX = 2'd2, DX = 2'd3;
`ifdef REGSEQ_FLAGS_EN
   localparam bit FL_EN = 1'b1;
`else
   localparam bit FL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, stall;
   logic [2:0] in_op;
   logic [1:0] in_dst, in_srca, in_srcb, aa, ab, ad;
   logic [7:0] in_imm, ra, rb, rd;
   logic       wr, addr_lock, flag_z, flag_c, done;
   logic [7:0] rf [4];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb),
      .in_imm(in_imm), .stall(stall), .aa(aa), .ab(ab), .ra(ra), .rb(rb),
      .wr(wr), .ad(ad), .rd(rd), .addr_lock(addr_lock), .flag_z(flag_z),
      .flag_c(flag_c), .done(done)
   );

   // Register file: asynchronous read, commit on the falling edge inside WB.
   assign ra = rf[aa];
   assign rb = rf[ab];
   always @(negedge clk) if (wr) rf[ad] <= rd;

   typedef struct {
      logic [2:0] op;
      logic [1:0] dst, sa, sb;
      logic [7:0] imm;
      int         ss, sl;
      logic [7:0] rd;
      logic       wr, z, c;
   } vec_t;

   vec_t tv [19];

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] dst, sa, sb,
                               input logic [7:0] imm, input int ss, sl,
                               input logic [7:0] erd, input logic ewr, ez, ec);
      vec_t v;
      v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.imm = imm;
      v.ss = ss; v.sl = sl; v.rd = erd; v.wr = ewr; v.z = ez; v.c = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int  n;
      bit  seen, early;
      in_op = v.op; in_dst = v.dst; in_srca = v.sa; in_srcb = v.sb; in_imm = v.imm;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("v%0d_accept", idx), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0; early = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         stall = (k >= v.ss) && (k < v.ss + v.sl);
         #1;
         if (stall) begin
            check($sformatf("v%0d_lock_c%0d", idx, k), addr_lock, 1);
            check($sformatf("v%0d_stall_wrdone_c%0d", idx, k), {wr, done}, 0);
         end
         if (done) begin
            seen = 1;
            check($sformatf("v%0d_latency", idx), k, 3 + v.sl);
            check($sformatf("v%0d_wr", idx), wr, v.wr);
            if (v.wr) begin
               check($sformatf("v%0d_ad", idx), ad, v.dst);
               check($sformatf("v%0d_rd", idx), rd, v.rd);
            end
            check($sformatf("v%0d_z", idx), flag_z, FL_EN ? v.z : 1'b0);
            check($sformatf("v%0d_c", idx), flag_c, FL_EN ? v.c : 1'b0);
         end else if (wr) begin
            early = 1;
         end
         if (!seen) begin
            @(posedge clk); #1;
         end
      end
      check($sformatf("v%0d_done_seen", idx), seen, 1);
      check($sformatf("v%0d_early_wr", idx), early, 0);
      @(posedge clk); #1;
      stall = 1'b0;
      #1;
      check($sformatf("v%0d_done_one", idx), {wr, done}, 0);
      check($sformatf("v%0d_ready_next", idx), in_ready, 1);
   endtask

   initial begin
      bit any_wr;
      tv[0]  = mk(LDI,  AX, AX, AX, 8'h5A, 0, 0, 8'h5A, 1, 0, 0);
      tv[1]  = mk(LDI,  AX, AX, AX, 8'hF0, 0, 0, 8'hF0, 1, 0, 0);
      tv[2]  = mk(LDI,  BX, AX, AX, 8'h20, 0, 0, 8'h20, 1, 0, 0);
      tv[3]  = mk(ADD,  CX, AX, BX, 8'h00, 0, 0, 8'h10, 1, 0, 1);
      tv[4]  = mk(MOV,  DX, CX, AX, 8'h00, 0, 0, 8'h10, 1, 0, 1);
      tv[5]  = mk(LDI,  BX, AX, AX, 8'h33, 0, 0, 8'h33, 1, 0, 1);
      tv[6]  = mk(SUB,  DX, BX, BX, 8'h00, 0, 0, 8'h00, 1, 1, 0);
      tv[7]  = mk(LDI,  AX, AX, AX, 8'h01, 0, 0, 8'h01, 1, 1, 0);
      tv[8]  = mk(LDI,  BX, AX, AX, 8'h02, 0, 0, 8'h02, 1, 1, 0);
      tv[9]  = mk(CMP,  CX, AX, BX, 8'h00, 0, 0, 8'hFF, 0, 0, 1);
      tv[10] = mk(MOV,  DX, CX, AX, 8'h00, 0, 0, 8'h10, 1, 0, 1);
      tv[11] = mk(AND_, CX, AX, BX, 8'h00, 0, 0, 8'h00, 1, 1, 0);
      tv[12] = mk(OR_,  DX, AX, BX, 8'h00, 0, 0, 8'h03, 1, 0, 0);
      tv[13] = mk(ADD,  BX, AX, BX, 8'h00, 2, 3, 8'h03, 1, 0, 0);
      tv[14] = mk(SUB,  AX, AX, BX, 8'h00, 3, 2, 8'hFE, 1, 0, 1);
      tv[15] = mk(ADD,  DX, AX, BX, 8'h00, 1, 1, 8'h01, 1, 0, 1);
      tv[16] = mk(LDI,  AX, AX, AX, 8'hFF, 0, 0, 8'hFF, 1, 0, 1);
      tv[17] = mk(LDI,  BX, AX, AX, 8'h01, 0, 0, 8'h01, 1, 0, 1);
      tv[18] = mk(ADD,  CX, AX, BX, 8'h00, 0, 0, 8'h00, 1, 1, 1);

      for (int i = 0; i < 4; i++) rf[i] = 8'h00;
      rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0;
      in_op = MOV; in_dst = AX; in_srca = AX; in_srcb = AX; in_imm = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", in_ready, 0);
      check("rst_wr_done", {wr, done}, 0);
      check("rst_addr", {aa, ab, ad}, 0);
      check("rst_rd", rd, 0);
      check("rst_flags", {flag_z, flag_c}, 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", in_ready, 1);

      for (int i = 0; i < 19; i++) run_op(tv[i], i);

      // Reset while the ADD sits in READ, with stall also asserted.
      in_op = ADD; in_dst = CX; in_srca = AX; in_srcb = BX; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_rst_aa_ab", {aa, ab}, {AX, BX});
      rst_n = 1'b0; stall = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_wr_done", {wr, done}, 0);
      check("mid_rst_addr", {aa, ab, ad}, 0);
      check("mid_rst_rd", rd, 0);
      check("mid_rst_flags", {flag_z, flag_c}, 0);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_lock", addr_lock, 1);
      rst_n = 1'b1; stall = 1'b0;
      #1;
      check("mid_rst_ready_after", in_ready, 1);
      any_wr = 0;
      repeat (5) begin
         @(posedge clk); #1;
         any_wr |= wr;
      end
      check("mid_rst_no_wr", any_wr, 0);
      check("mid_rst_cx_kept", rf[CX], 8'h00);
      run_op(mk(LDI, DX, AX, AX, 8'h77, 0, 0, 8'h77, 1, 0, 0), 19);
      run_op(mk(MOV, AX, DX, AX, 8'h00, 0, 0, 8'h77, 1, 0, 0), 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Register-file initiator for the 8-bit CPU datapath. Accepts one decoded register operation per handshake, drives the register file's two read-address ports, captures both operands, computes an 8-bit ALU result, and drives the write-back port (`wr`/`ad`/`rd`). It also owns the register file's `addr_lock` freeze line and the Z/C status flags. It sits between the instruction decoder and the four-entry register file (AX, BX, CX, DX).

## Interface
- `rst_n` reset is synchronous, active-low.
- No parameters. Data width is fixed at 8 bits and register address width at 2 bits.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  decoder presents an operation
- `in_ready`  out  1  sequencer accepts an operation this cycle
- `in_op`  in  3  opcode: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 CMP
- `in_dst`  in  2  destination register
- `in_srca`  in  2  source A register
- `in_srcb`  in  2  source B register
- `in_imm`  in  8  immediate operand (LDI only)
- `stall`  in  1  freeze request from the memory or fetch side
- `aa`  out  2  read address port A
- `ab`  out  2  read address port B
- `ra`  in  8  read data A
- `rb`  in  8  read data B
- `wr`  out  1  write enable
- `ad`  out  2  write address
- `rd`  out  8  write data
- `addr_lock`  out  1  register file freeze
- `flag_z`  out  1  zero flag
- `flag_c`  out  1  carry/borrow flag
- `done`  out  1  one-cycle pulse when an operation retires

## Operation
- The FSM has four states: IDLE → READ → EXEC → WB → IDLE.
- **Accept:** `in_ready` = (state==IDLE) && !`stall`. On `in_valid && in_ready`, latch op, dst, srca, srcb and imm, then go to READ.
- **READ:** `aa` = srca and `ab` = srcb, both registered and driven from READ onward. At the end of READ, capture `ra` and `rb` into the operand registers opA and opB.
- **EXEC:** compute the 9-bit result `res`:
  - ADD: {0,opA} + {0,opB}
  - SUB and CMP: {0,opA} − {0,opB}; bit 8 = borrow.
  - AND, OR, XOR: bitwise result, bit 8 = 0.
  - MOV: result = opA.
  - LDI: result = imm.
- **Flags:** updated at the end of EXEC for ADD, SUB, AND, OR, XOR and CMP.
  - Z = (res[7:0]==0).
  - C = res[8].
  - MOV and LDI leave the flags unchanged.
- **WB:**
  - `ad` = dst, `rd` = res[7:0].
  - `wr` = 1 for every op except CMP; CMP drives `wr` = 0.
  - `done` = 1.
  - The next state is IDLE.
- **Stall:** while `stall`=1:
  - The state and all internal and output registers hold.
  - `addr_lock` = `stall`, combinationally.
  - `wr` and `done` are forced to 0.
  - When stall drops in WB, the write and `done` occur on the first unstalled cycle.
- `aa`, `ab`, `ad` and `rd` hold their last values in IDLE.
- **Reset values:** state IDLE; `aa`, `ab` and `ad` = 0; `rd` = 0; `wr` = 0; `done` = 0; flags = 0; `in_ready` = 0 during reset.

## Timing
- Cycle 0 is the accept edge. READ occupies cycle 1, EXEC cycle 2, and WB cycle 3.
- `done` and `wr` are high for exactly cycle 3 when there is no stall.
- Throughput is one operation per 4 cycles. `in_ready` rises in cycle 4.
- The register file commits on the falling edge inside WB, so an operation accepted in cycle 4 reads the updated value in its READ cycle. No forwarding is needed.
- Each stalled cycle adds exactly one cycle of latency.
- **Reset mid-operation:** the operation is abandoned with no write. `wr` is 0 on the cycle after the reset edge. A `stall` present during reset does not block reset.
- **Same-source reads:** srca==srcb and dst==srca are legal. Both read ports return the same register, e.g. SUB with A=A gives 0, Z=1, C=0.
- `in_valid` while not ready is ignored, and the decoder holds the operation.

## Configuration
- `REGSEQ_FLAGS_EN` defined:
  - The Z/C flag registers and CMP behave as above.
- Not defined:
  - `flag_z` and `flag_c` are tied to 0.
  - CMP runs through all states as a no-op: no write, `done` still pulses.
  - No flag logic is synthesized.

## Test plan
- Reset, then LDI dst=AX imm=0x5A → `wr`=1, `ad`=0, `rd`=0x5A in cycle 3; `done` pulses once; `in_ready`=1 in cycle 4.
- AX=0xF0, BX=0x20, ADD dst=CX A=AX B=BX → `rd`=0x10, C=1, Z=0. Then MOV DX←CX reads 0x10 with no extra delay.
- SUB with A=BX, B=BX (BX=0x33) → `rd`=0x00, Z=1, C=0. CMP AX(0x01) vs BX(0x02) → `wr`=0, C=1, Z=0, and register values are unchanged.
- Hold `stall`=1 for 3 cycles starting in EXEC of an ADD → `addr_lock`=1 for those cycles; `wr` rises 3 cycles late and lasts exactly one cycle; the result is unchanged.
- Assert `rst_n`=0 during READ of an ADD → no `wr` pulse, all outputs return to reset values, and the next operation completes normally.
- With `REGSEQ_FLAGS_EN` undefined → CMP pulses `done` with `wr`=0, and the flags stay 0 after ADD 0xFF+0x01.
